// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first, start/busy/done handshake.
// Define BCD_SUB_EN to add the 'sub' port (ten's-complement subtraction A - B).
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CW     = $clog2(DIGITS) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  input  logic                start,
  input  logic [4*DIGITS-1:0] in0,
  input  logic [4*DIGITS-1:0] in1,
  output logic [4*DIGITS-1:0] out,
  output logic                cout,
  output logic                busy,
  output logic                done,
  output logic                flag
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic [4*DIGITS-1:0] r_work;
  logic [4*DIGITS-1:0] r_out;
  logic [CW-1:0]       r_idx;
  logic                r_carry;
  logic                r_err;
  logic                r_cout;
  logic                r_busy;
  logic                r_done;
  logic                r_flag;
  logic                r_sub;

  logic                w_start_carry;
  logic [3:0]          w_a;
  logic [3:0]          w_b;
  logic [3:0]          w_af;
  logic [3:0]          w_bf;
  logic                w_err;
  logic [4:0]          w_sum;
  logic [3:0]          w_digit;
  logic                w_carry;
  logic                w_last;
  logic [4*DIGITS-1:0] w_work_next;

`ifdef BCD_SUB_EN
  assign w_start_carry = sub;
`else
  assign w_start_carry = 1'b0;
`endif

  always_comb begin
    w_a = '0;
    w_b = '0;
    w_work_next = r_work;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == CW'(i)) begin
        w_a = r_a[4*i +: 4];
        w_b = r_b[4*i +: 4];
      end
    end
    w_err = (w_a > 4'd9) || (w_b > 4'd9);
    w_af  = (w_a > 4'd9) ? '0 : w_a;
    w_bf  = (w_b > 4'd9) ? '0 : w_b;
    // Nines-complement after filtering so an invalid B digit subtracts as 0.
    if (r_sub) w_bf = 4'd9 - w_bf;
    w_sum = {1'b0, w_af} + {1'b0, w_bf} + {4'b0000, r_carry};
    if (w_sum > 5'd9) begin
      w_digit = w_sum[3:0] + 4'd6;
      w_carry = 1'b1;
    end else begin
      w_digit = w_sum[3:0];
      w_carry = 1'b0;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == CW'(i)) w_work_next[4*i +: 4] = w_digit;
    end
    w_last = (r_idx == CW'(DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_out   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_flag  <= 1'b0;
      r_sub   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= in0;
            r_b     <= in1;
            r_sub   <= w_start_carry;
            r_idx   <= '0;
            r_carry <= w_start_carry;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_work  <= w_work_next;
          r_idx   <= r_idx + 1'b1;
          r_carry <= w_carry;
          r_err   <= r_err | w_err;
          if (w_last) begin
            r_out   <= w_work_next;
            r_cout  <= w_carry;
            r_flag  <= r_err | w_err;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out  = r_out;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;
  assign flag = r_flag;

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Multi-digit packed-BCD adder, parametrised in digit count.
- Processes one decimal digit per clock, least-significant digit first, using a digit-serial adder with a registered decimal carry.
- Operands arrive with a start/busy/done handshake. Invalid input digits are filtered to 0 and reported on a sticky-per-operation flag.
- Sits between the keypad/operand registers and the BCD display path. It is the multi-digit, clocked successor of the single-digit combinational BCD adder.

Parameters:
- DIGITS, 4, number of BCD digits per operand and result (legal range 1..16).
- CW, $clog2(DIGITS)+1, digit-index counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the block is not busy.
- in0  input  4*DIGITS  BCD operand A; digit 0 at bits [3:0].
- in1  input  4*DIGITS  BCD operand B; same packing as in0.
- out  output  4*DIGITS  BCD result, registered.
- cout  output  1  decimal carry out of the top digit, registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when out/cout update.
- flag  output  1  any input digit > 9 in the last completed operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out=0, cout=0, busy=0, done=0, flag=0; internal operand, work and index registers cleared.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge t0:
  - latch in0/in1 into operand registers; idx=0; carry=0; pending error=0.
  - state becomes RUN; busy=1 from t0 on.
- start=0 in IDLE: stay in IDLE. DONE with start=0: go to IDLE next edge.
- RUN, each edge, for digit idx:
  - a = A[idx], b = B[idx]. Any digit > 9 is replaced by 0 and sets the pending error.
  - s = a + b + carry (5 bits). If s > 9: digit = s+6 (low 4 bits), carry=1. Else digit = s, carry=0.
  - digit is written into the work register at position idx; idx increments.
- RUN, edge at which idx == DIGITS-1 (edge t0+DIGITS):
  - out = full work register including this digit; cout = final carry; flag = pending error.
  - state becomes DONE; busy=0; done=1 for exactly one cycle.
- Latency: done is high during the cycle after edge t0+DIGITS. Back-to-back throughput is one operation per DIGITS+1 cycles.
- out, cout and flag hold their previous values throughout RUN. They change only at the completion edge.
- start while busy=1 is ignored. No queueing; operands are not re-latched.
- in0/in1 may change freely after t0; only the latched copy is used.
- DIGITS=1: RUN lasts one edge; same rules apply.
- The result wraps modulo 10^DIGITS; overflow is visible only on cout.
- Reset mid-RUN: operation aborted, all outputs return to their reset values, done does not pulse.

Optional Feature:
- Macro BCD_SUB_EN.
- Defined:
  - adds input port sub (1 bit), latched with the operands at start.
  - When sub=1, B digits are nines-complemented (9-b, after filtering) and the initial carry is 1. Result = A - B modulo 10^DIGITS.
  - cout=1 means A >= B (no borrow); cout=0 means a negative result shown as its ten's complement.
  - When sub=0, behaviour is identical to addition.
- Undefined: no sub port, addition only; all timing is identical in both builds.

Test Plan:
- DIGITS=4, in0=0x1234, in1=0x4321, start pulse -> done 4 edges later; out=0x5555, cout=0, flag=0; busy high exactly 4 cycles.
- in0=0x9999, in1=0x0001 -> out=0x0000, cout=1; then 0x0999+0x0001 -> out=0x1000, cout=0 (carry ripple across all digits).
- in0=0x00A5, in1=0x0005 -> out=0x0010, flag=1. The next operation 0x0001+0x0001 -> out=0x0002, flag=0 (flag recomputed per operation).
- Start 0x0011+0x0022, reassert start with 0x5000+0x5000 at cycle 2 -> ignored; out=0x0033 once. Start during the DONE cycle -> accepted, busy next cycle.
- Start an operation, drop rst_n at cycle 2 -> out=0, cout=0, busy=0, flag=0 immediately, no done pulse; post-reset 0x0002+0x0003 -> out=0x0005.
- BCD_SUB_EN, sub=1: 0x0100-0x0001 -> out=0x0099, cout=1; 0x0001-0x0002 -> out=0x9999, cout=0; sub=0 with 0x1234+0x4321 -> 0x5555.
